// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 types and constants, plus the combinational Float16Mul/Float16Add units.
// Subnormal inputs and results flush to signed zero; rounding is nearest-even.
package fp16_pkg;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam int FP16_SIGN_BIT = 15;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    typedef logic [15:0] fp16_t;
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} mac_state_e;

    // A rounding carry out of the mantissa bumps the exponent, reaching Inf naturally
    function automatic fp16_t fp16_pack(input logic s, input int e, input logic [9:0] m,
                                        input logic g, input logic st);
        logic [14:0] r;
        if (e <= 0) return {s, 15'd0};
        if (e >= 31) return {s, 5'h1f, 10'd0};
        r = {e[4:0], m} + {14'd0, g & (st | m[0])};
        return {s, r};
    endfunction

    function automatic fp16_t Float16Mul(input fp16_t a, input fp16_t b);
        logic s;
        logic [21:0] p;
        int e;
        s = a[15] ^ b[15];
        if ((&a[14:10] && |a[9:0]) || (&b[14:10] && |b[9:0])) return FP16_QNAN;
        if (&a[14:10] || &b[14:10])
            return (a[14:10] == 5'd0 || b[14:10] == 5'd0) ? FP16_QNAN : {s, 5'h1f, 10'd0};
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        return p[21] ? fp16_pack(s, e + 1, p[20:11], p[10], |p[9:0])
                     : fp16_pack(s, e, p[19:10], p[9], |p[8:0]);
    endfunction

    function automatic fp16_t Float16Add(input fp16_t a, input fp16_t b);
        fp16_t x, y;
        logic [13:0] mx, my;
        logic [14:0] sum;
        int e, d;
        if ((&a[14:10] && |a[9:0]) || (&b[14:10] && |b[9:0])) return FP16_QNAN;
        if (&a[14:10] && &b[14:10] && (a[15] != b[15])) return FP16_QNAN;
        if (&a[14:10]) return a;
        if (&b[14:10]) return b;
        if (a[14:10] == 5'd0) return (b[14:10] == 5'd0) ? {a[15] & b[15], 15'd0} : b;
        if (b[14:10] == 5'd0) return a;
        {x, y} = (a[14:0] >= b[14:0]) ? {a, b} : {b, a};
        d = int'(x[14:10]) - int'(y[14:10]);
        mx = {1'b1, x[9:0], 3'd0};
        my = {1'b1, y[9:0], 3'd0};
        // Three extra bits below the mantissa: guard, round and a sticky OR of everything shifted out
        my = (d > 13) ? 14'd1 : (my >> d) | {13'd0, |(my & ~(14'h3fff << d))};
        e = int'(x[14:10]);
        if (x[15] == y[15]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[14]) begin
                sum = {1'b0, sum[14:2], sum[1] | sum[0]};
                e = e + 1;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, my};
            if (sum == 15'd0) return FP16_ZERO;
            for (int i = 0; i < 13; i++)
                if (!sum[13]) begin
                    sum = sum << 1;
                    e = e - 1;
                end
        end
        return fp16_pack(x[15], e, sum[12:3], sum[2], |sum[1:0]);
    endfunction
endpackage

// File: rtl/fp16_mac_lane.sv
// fp16_mac_lane: one accumulator lane; registered product feeding a registered accumulator.
module fp16_mac_lane
    import fp16_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_bias,
    input  fp16_t bias,
    input  logic  beat_en,
    input  logic  prod_vld,
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t acc
);
    fp16_t prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= FP16_ZERO;
            acc  <= FP16_ZERO;
        end else begin
            if (beat_en) prod <= Float16Mul(a, b);
            if (load_bias) acc <= bias;
            else if (prod_vld) acc <= Float16Add(acc, prod);
        end
    end
endmodule

// File: rtl/fp16_mac_array.sv
// fp16_mac_array: handshaked multi-lane FP16 dot-product engine with bias preload and optional ReLU.
// Operand A is shared across lanes; each lane takes its own B slice and bias.
module fp16_mac_array
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    input  logic                        relu_en,
    input  logic [LANES*DATA_WIDTH-1:0] bias,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data
);
    mac_state_e state, next;
    logic [LEN_WIDTH-1:0] cnt, len_q;
    logic relu_q, prod_vld, accept, load, emit;
    logic [LANES*DATA_WIDTH-1:0] result;

    assign in_ready = state == ACC;
    assign busy     = state != IDLE;
    assign accept   = in_ready && in_valid;
    assign load     = state == IDLE && start;
    assign emit     = state == DRAIN && !prod_vld;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = (len == '0) ? DRAIN : ACC;
            ACC:     if (accept && cnt == len_q - LEN_WIDTH'(1)) next = DRAIN;
            DRAIN:   if (!prod_vld) next = DONE;
            DONE:    if (out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            relu_q    <= 1'b0;
            prod_vld  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state    <= next;
            prod_vld <= accept;
            if (load) begin
                cnt    <= '0;
                len_q  <= len;
                relu_q <= relu_en;
            end
            if (accept) cnt <= cnt + LEN_WIDTH'(1);
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= result;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp16_t acc;
        fp16_mac_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .load_bias (load),
            .bias      (bias[i*DATA_WIDTH +: DATA_WIDTH]),
            .beat_en   (accept),
            .prod_vld  (prod_vld),
            .a         (in_a),
            .b         (in_b[i*DATA_WIDTH +: DATA_WIDTH]),
            .acc       (acc)
        );
        // Any set sign bit, including -0.0, clamps to +0
        assign result[i*DATA_WIDTH +: DATA_WIDTH] = (relu_q && acc[FP16_SIGN_BIT]) ? FP16_ZERO : acc;
    end
endmodule

// File: tb/tb_fp16_mac_array.sv
// tb_fp16_mac_array: scenario tasks with a queue of expected result vectors.
module tb_fp16_mac_array;
    logic clk = 1'b0;
    logic reset, start, relu_en, in_valid, in_ready, busy, out_valid, out_ready;
    logic [9:0]  len;
    logic [15:0] in_a;
    logic [63:0] bias, in_b, out_data;
    int total = 0, bad = 0, cyc = 0, last_acc = 0;
    logic [63:0] exp_q[$];
    logic [15:0] a_seq[8];
    logic [63:0] b_seq[8];

    fp16_mac_array #(.DATA_WIDTH(16), .LANES(4), .LEN_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .relu_en(relu_en), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_job(input logic [9:0] l, input logic r, input logic [63:0] bs, input int gaps);
        int g;
        start = 1'b1; len = l; relu_en = r; bias = bs;
        tick();
        start = 1'b0; len = '0; relu_en = 1'b0; bias = '0;
        for (int k = 0; k < int'(l); k++) begin
            if (gaps != 0) begin
                g = (k == 0) ? 2 : int'($urandom_range(3, 0));
                for (int j = 0; j < g; j++) begin
                    start = (j == 0);
                    in_a = 16'($urandom);
                    in_b = {$urandom, $urandom};
                    tick();
                    start = 1'b0;
                end
            end
            in_valid = 1'b1; in_a = a_seq[k]; in_b = b_seq[k];
            tick();
            in_valid = 1'b0;
        end
        last_acc = cyc;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; len = 0; relu_en = 0; bias = 0;
        in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        #1;
        total++;
        if ({in_ready, busy, out_valid, out_data} !== 67'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {in_ready, busy, out_valid, out_data});
        end
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        logic [63:0] e;
        a_seq[0] = 16'h3C00; a_seq[1] = 16'h4000; a_seq[2] = 16'h4200;
        for (int k = 0; k < 3; k++) b_seq[k] = {4{16'h3C00}};
        exp_q.push_back({4{16'h4600}});
        drive_job(3, 1'b0, 64'd0, 0);
        wait_out(n);
        total++;
        if (n !== 2 || cyc - last_acc !== 2) begin
            bad++;
            $display("FAIL basic_latency got=%0d exp=2", n);
        end
        e = exp_q.pop_front();
        total++;
        if (out_data !== e) begin
            bad++;
            $display("FAIL basic_data got=%h exp=%h", out_data, e);
        end
        ack();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_release got=%b%b exp=00", out_valid, busy);
        end
    endtask

    task automatic test_bias();
        int n;
        logic [63:0] e;
        for (int k = 0; k < 2; k++) begin
            a_seq[k] = 16'h4000;
            b_seq[k] = {4{16'h4000}};
        end
        exp_q.push_back({4{16'h4880}});
        drive_job(2, 1'b0, {4{16'h3C00}}, 0);
        wait_out(n);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            bad++;
            $display("FAIL bias_data got=%h exp=%h", out_data, e);
        end
        ack();
        b_seq[0] = {16'h4000, 16'h4000, 16'h3C00, 16'h4000};
        exp_q.push_back({16'h4500, 16'h4500, 16'h4200, 16'h4500});
        drive_job(1, 1'b0, {4{16'h3C00}}, 0);
        wait_out(n);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            bad++;
            $display("FAIL lane_distinct got=%h exp=%h", out_data, e);
        end
        ack();
    endtask

    task automatic test_relu();
        int n;
        logic [63:0] e;
        a_seq[0] = 16'hBC00;
        b_seq[0] = {4{16'h4200}};
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back((r == 0) ? {4{16'hC200}} : 64'd0);
            drive_job(1, r[0], 64'd0, 0);
            wait_out(n);
            e = exp_q.pop_front();
            total++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                bad++;
                $display("FAIL relu_%0d got=%h exp=%h", r, out_data, e);
            end
            ack();
        end
        exp_q.push_back(64'd0);
        drive_job(0, 1'b1, {4{16'h8000}}, 0);
        wait_out(n);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            bad++;
            $display("FAIL relu_neg_zero got=%h exp=%h", out_data, e);
        end
        ack();
    endtask

    task automatic test_stall();
        int n;
        logic [63:0] e, held;
        a_seq[0] = 16'h3C00; a_seq[1] = 16'h4000; a_seq[2] = 16'h4200;
        for (int k = 0; k < 3; k++) b_seq[k] = {4{16'h3C00}};
        exp_q.push_back({4{16'h4600}});
        drive_job(3, 1'b0, 64'd0, 1);
        wait_out(n);
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            bad++;
            $display("FAIL stall_data got=%h exp=%h", out_data, e);
        end
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            tick();
            start = 1'b0;
            total++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                bad++;
                $display("FAIL stall_hold_%0d got=%b/%h exp=1/%h", k, out_valid, out_data, held);
            end
        end
        out_ready = 1'b1; start = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_start_in_done got=%b%b exp=00", out_valid, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_len0();
        int n;
        logic [63:0] e;
        exp_q.push_back({4{16'h4600}});
        drive_job(0, 1'b0, {4{16'h4600}}, 0);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL len0_ready got=%b exp=0", in_ready);
        end
        wait_out(n);
        e = exp_q.pop_front();
        total++;
        if (n !== 1 || out_data !== e) begin
            bad++;
            $display("FAIL len0_out got=%0d/%h exp=1/%h", n, out_data, e);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            a_seq[k] = 16'h4000;
            b_seq[k] = {4{16'h4000}};
        end
        start = 1'b1; len = 10'd4; bias = {4{16'h3C00}};
        tick();
        start = 1'b0; len = '0; bias = '0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_a = a_seq[k]; in_b = b_seq[k];
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if ({in_ready, busy, out_valid, out_data} !== 67'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h exp=0", {in_ready, busy, out_valid, out_data});
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_quiet got=%b%b exp=00", out_valid, busy);
        end
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias();
        test_relu();
        test_stall();
        test_len0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
